// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-backed UART transmitter: FSM states, register
// addresses, parity mode codes and status/control bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIVL = 2'd2;
    localparam logic [1:0] ADDR_DIVH = 2'd3;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;

    localparam int ST_ACTIVE_BIT    = 0;
    localparam int ST_EMPTY_BIT     = 1;
    localparam int ST_FULL_BIT      = 2;
    localparam int ST_OVF_BIT       = 3;
    localparam int CTRL_IRQ_BIT     = 0;
    localparam int CTRL_CLR_OVF_BIT = 7;

    // Mode 11 behaves like 00: no parity bit in the frame.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; full is judged before a
// same-cycle pop so a push into a full FIFO is always refused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with transmit FIFO, runtime divisor and optional parity.
// UART_TX_FIFO_LEVEL_EN adds a fill-level field to status and a half-drain interrupt.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 50_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_addr,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_we,
    input  logic       i_cyc,
    output logic       tx,
    output logic       o_int
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(SYS_CLK / BAUDRATE);

    tx_state_e              state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       div_lat_q, div_lat_d;
    logic [DIV_W-1:0]       baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [2:0]             ctrl_q, ctrl_d;
    logic                   ovf_q, ovf_d;
    logic                   par_en_q, par_en_d;
    logic                   par_bit_q, par_bit_d;
    logic                   tx_q, tx_d;
    logic                   int_q, int_d;

    logic                   bus_wr, fifo_push, fifo_pop, load, tick, lvl_irq;
    logic                   fifo_full, fifo_empty;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic [CW-1:0]          fifo_count;
    logic [3:0]             level_nib;
    logic [7:0]             status;

    assign bus_wr    = i_cyc && i_we;
    assign fifo_push = bus_wr && (i_addr == ADDR_DATA);
    assign tick      = (baud_q == div_lat_q - 1'b1);

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .push_i   (fifo_push),
        .data_i   (i_dat[DATA_BITS-1:0]),
        .pop_i    (fifo_pop),
        .data_o   (fifo_dout),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

`ifdef UART_TX_FIFO_LEVEL_EN
    assign level_nib = (int'(fifo_count) > 15) ? 4'hF : 4'(fifo_count);
    assign lvl_irq   = fifo_pop && !fifo_push && ctrl_q[CTRL_IRQ_BIT]
                       && (fifo_count == CW'(FIFO_DEPTH / 2));
`else
    logic unused_count;
    assign unused_count = ^fifo_count;
    assign level_nib    = 4'h0;
    assign lvl_irq      = 1'b0;
`endif

    // A write with the clear-ovf bit set only clears ovf; ctrl keeps its value.
    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        ovf_d  = ovf_q;
        if (bus_wr) begin
            case (i_addr)
                ADDR_DATA: if (fifo_full) ovf_d = 1'b1;
                ADDR_CTRL: begin
                    if (i_dat[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
                    else                         ctrl_d = i_dat[2:0];
                end
                ADDR_DIVL: div_d[7:0] = i_dat;
                ADDR_DIVH: div_d = DIV_W'({i_dat, div_q[7:0]});
                default:   ;
            endcase
        end
    end

    always_comb begin
        status                   = {level_nib, 4'b0};
        status[ST_ACTIVE_BIT]    = (state_q != IDLE);
        status[ST_EMPTY_BIT]     = fifo_empty;
        status[ST_FULL_BIT]      = fifo_full;
        status[ST_OVF_BIT]       = ovf_q;
        case (i_addr)
            ADDR_DATA: o_dat = status;
            ADDR_CTRL: o_dat = {5'b0, ctrl_q};
            ADDR_DIVL: o_dat = div_q[7:0];
            default:   o_dat = 8'(div_q >> 8);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        div_lat_d = div_lat_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        int_d     = 1'b0;
        load      = 1'b0;
        if (state_q != IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE:  load = !fifo_empty;
            START: if (tick) begin
                state_d = DATA;
                tx_d    = shift_q[0];
                bit_d   = '0;
            end
            DATA: if (tick) begin
                if (bit_q == 3'(DATA_BITS - 1)) begin
                    bit_d = '0;
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                    bit_d   = bit_q + 1'b1;
                end
            end
            PARITY: if (tick) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: if (tick) begin
                if (bit_q == 3'(STOP_BITS - 1)) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        int_d   = ctrl_q[CTRL_IRQ_BIT];
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Frame start: divisor and parity are sampled here so mid-frame writes wait.
        if (load) begin
            state_d   = START;
            shift_d   = fifo_dout;
            div_lat_d = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
            baud_d    = '0;
            bit_d     = '0;
            tx_d      = 1'b0;
            par_en_d  = parity_enabled(ctrl_q[2:1]);
            par_bit_d = (^fifo_dout) ^ (ctrl_q[2:1] == PAR_ODD);
        end
        int_d = int_d | lvl_irq;
    end

    assign fifo_pop = load;
    assign tx       = tx_q;
    assign o_int    = int_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            div_q     <= DIV_RST;
            div_lat_q <= DIV_RST;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            ctrl_q    <= '0;
            ovf_q     <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            int_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ctrl_q    <= ctrl_d;
            ovf_q     <= ovf_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            int_q     <= int_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected serial frames, a
// line monitor decodes tx cycle by cycle and checks each frame against the queue.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int DIV = 4;
`ifdef UART_TX_FIFO_LEVEL_EN
    localparam int LVL = 1;
`else
    localparam int LVL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdat = 8'h00;
    logic [7:0] rdat;
    logic       we = 1'b0;
    logic       cyc = 1'b0;
    logic       tx;
    logic       irq;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_addr   (addr),
        .i_dat    (wdat),
        .o_dat    (rdat),
        .i_we     (we),
        .i_cyc    (cyc),
        .tx       (tx),
        .o_int    (irq)
    );

    typedef struct {
        logic [11:0] bits;
        int          nbits;
        bit          b2b;
        logic [7:0]  data;
    } frame_t;

    frame_t sb_q[$];
    int     errors = 0;
    int     checks = 0;
    int     int_cnt = 0;
    bit     mon_off = 1'b0;
    bit     mon_busy = 1'b0;

    always @(negedge clk) if (irq === 1'b1) int_cnt <= int_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // par: 0 none, 1 present with bit value pbit
    task automatic expect_frame(input logic [7:0] d, input bit par, input logic pbit, input bit b2b);
        frame_t f;
        f.bits     = '0;
        f.bits[8:1] = d;
        if (par) begin
            f.bits[9]  = pbit;
            f.bits[10] = 1'b1;
            f.nbits    = 11;
        end else begin
            f.bits[9]  = 1'b1;
            f.nbits    = 10;
        end
        f.b2b  = b2b;
        f.data = d;
        sb_q.push_back(f);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdat = d; we = 1'b1; cyc = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; cyc = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = rdat;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, %0d frames still pending, expected 0", name, sb_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Line monitor: every cycle of every bit must carry the expected level.
    initial begin : monitor
        int     gap;
        int     bad;
        frame_t e;
        logic [11:0] act;
        gap = 1000;
        forever begin
            @(negedge clk);
            if (!rst_n || mon_off) begin
                gap = 1000;
            end else if (tx === 1'b0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame: unexpected start bit at %0t, expected idle line", $time);
                    gap = 1000;
                end else begin
                    e = sb_q.pop_front();
                    mon_busy = 1'b1;
                    bad = 0;
                    act = '0;
                    for (int k = 0; k < e.nbits * DIV; k++) begin
                        if (k > 0) @(negedge clk);
                        if ((k % DIV) == DIV / 2) act[k / DIV] = tx;
                        if (tx !== e.bits[k / DIV]) bad++;
                    end
                    check($sformatf("frame 0x%02h bits", e.data), act, e.bits);
                    check($sformatf("frame 0x%02h bad cycles", e.data), bad, 0);
                    if (e.b2b) check($sformatf("frame 0x%02h idle gap", e.data), gap, 0);
                    gap = 0;
                    mon_busy = 1'b0;
                end
            end else begin
                gap++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] ctrl;
        bit         par;
        logic       pbit;
    } par_vec_t;

    initial begin : stim
        int       i0;
        par_vec_t pv[5];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", tx, 1'b1);
        check("reset o_int", irq, 1'b0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_check("reset status", 2'd0, 8'h02);
        read_check("reset ctrl", 2'd1, 8'h00);
        read_check("reset divl", 2'd2, 8'hB2);
        read_check("reset divh", 2'd3, 8'h01);

        // Configure div=4, irq enable, no parity
        bus_write(2'd2, 8'h04);
        bus_write(2'd3, 8'h00);
        bus_write(2'd1, 8'h01);
        read_check("divl readback", 2'd2, 8'h04);
        read_check("ctrl readback", 2'd1, 8'h01);

        // Single byte 0xA5 with first-bit latency
        i0 = int_cnt;
        expect_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        bus_write(2'd0, 8'hA5);
        check("latency tx before pop", tx, 1'b1);
        @(posedge clk);
        #1;
        check("latency tx start", tx, 1'b0);
        read_check("status during frame", 2'd0, 8'h03);
        wait_idle("A5 frame");
        check("A5 irq count", int_cnt - i0, 1);
        read_check("status after A5", 2'd0, 8'h02);

        // Three back-to-back frames, one interrupt at the end
        i0 = int_cnt;
        expect_frame(8'h11, 1'b0, 1'b0, 1'b0);
        expect_frame(8'h22, 1'b0, 1'b0, 1'b1);
        expect_frame(8'h33, 1'b0, 1'b0, 1'b1);
        bus_write(2'd0, 8'h11);
        bus_write(2'd0, 8'h22);
        bus_write(2'd0, 8'h33);
        wait_idle("3 frames");
        check("3 frames irq count", int_cnt - i0, 1);
        read_check("status after 3 frames", 2'd0, 8'h02);

        // Overflow: line busy with 0x40, then 16 accepted writes and one dropped
        i0 = int_cnt;
        expect_frame(8'h40, 1'b0, 1'b0, 1'b0);
        bus_write(2'd0, 8'h40);
        for (int k = 1; k <= 16; k++) begin
            expect_frame(8'(8'h40 + k), 1'b0, 1'b0, 1'b1);
            bus_write(2'd0, 8'(8'h40 + k));
        end
        bus_write(2'd0, 8'h5F);
        read_check("status overflow", 2'd0, (LVL != 0) ? 8'hFD : 8'h0D);
        bus_write(2'd1, 8'h80);
        read_check("ctrl after ovf clear", 2'd1, 8'h01);
        read_check("status ovf cleared", 2'd0, (LVL != 0) ? 8'hF5 : 8'h05);
        wait_idle("overflow frames");
        check("overflow irq count", int_cnt - i0, 1 + LVL);
        read_check("status after overflow", 2'd0, 8'h02);

        // Parity vectors: {data, ctrl, parity present, parity bit}
        pv[0] = '{8'h03, 8'h05, 1'b1, 1'b1};
        pv[1] = '{8'h03, 8'h03, 1'b1, 1'b0};
        pv[2] = '{8'h07, 8'h03, 1'b1, 1'b1};
        pv[3] = '{8'h07, 8'h05, 1'b1, 1'b0};
        pv[4] = '{8'h03, 8'h07, 1'b0, 1'b0};
        foreach (pv[k]) begin
            bus_write(2'd1, pv[k].ctrl);
            expect_frame(pv[k].data, pv[k].par, pv[k].pbit, 1'b0);
            bus_write(2'd0, pv[k].data);
            wait_idle($sformatf("parity vector %0d", k));
        end
        bus_write(2'd1, 8'h01);

`ifdef UART_TX_FIFO_LEVEL_EN
        // Fill level and half-drain interrupt
        i0 = int_cnt;
        for (int k = 0; k < 10; k++) begin
            expect_frame(8'(8'h60 + k), 1'b0, 1'b0, k > 0);
            bus_write(2'd0, 8'(8'h60 + k));
        end
        read_check("status level 9", 2'd0, 8'h91);
        wait_idle("level frames");
        check("level irq count", int_cnt - i0, 2);
`endif

        // Asynchronous reset in the middle of a data bit
        mon_off = 1'b1;
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'h0E);
        repeat (8) @(posedge clk);
        #2;
        check("tx low mid-data", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("tx forced high by reset", tx, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_off = 1'b0;
        read_check("status after reset", 2'd0, 8'h02);
        read_check("divl after reset", 2'd2, 8'hB2);
        read_check("divh after reset", 2'd3, 8'h01);
        read_check("ctrl after reset", 2'd1, 8'h00);
        repeat (20) @(posedge clk);
        #1;
        check("tx idle after reset", tx, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
